// File: rtl/ahb_sram_if.sv
// AHB-Lite slave front end for four byte-lane SRAM banks, with a BIST stall and illegal-transfer detection.
// Define AHB_SRAM_ERR_RESP_EN to give illegal transfers the two-cycle ERROR response; otherwise they complete OKAY.
module ahb_sram_if #(
   parameter int SRAM_AW = 13,
   parameter int HADDR_W = 32,
   parameter int NBANK   = 4
) (
   input  logic               sram_clk,
   input  logic               sram_rst,
   input  logic               hsel,
   input  logic [HADDR_W-1:0] haddr,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [31:0]        hwdata,
   input  logic               hready,
   output logic               hreadyout,
   output logic               hresp,
   output logic [31:0]        hrdata,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   output logic [NBANK-1:0]   sram_wen,
   output logic [NBANK-1:0]   sram_csn,
   input  logic [31:0]        sram_rdata,
   input  logic               bist_en,
   input  logic [NBANK-1:0]   b_done,
   input  logic [NBANK-1:0]   b_fail,
   output logic               bist_busy,
   output logic               bist_fail
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ACCESS = 3'd1;
   localparam logic [2:0] ST_STALL  = 3'd2;
   localparam logic [2:0] ST_ERR1   = 3'd3;
   localparam logic [2:0] ST_ERR2   = 3'd4;

   logic [2:0]         state, state_nx, decode_nx;
   logic [SRAM_AW-1:0] addr_p0;
   logic               write_p0, ill_p0;
   logic [NBANK-1:0]   mask_p0, mask_a;
   logic               accept, take, illegal, in_access;
   logic               unused_haddr;

   assign unused_haddr = ^haddr[HADDR_W-1:SRAM_AW+2];

   assign bist_busy = bist_en & ~&b_done;
   assign accept    = hsel & hready & htrans[1];
   // ERR2 drops any accept so the errored master can cancel its pipelined transfer
   assign take      = accept & ((state == ST_IDLE) | (state == ST_ACCESS));

   assign illegal = (hsize > 3'b010)
                  | ((hsize == 3'b001) & haddr[0])
                  | ((hsize == 3'b010) & (|haddr[1:0]));

   always_comb begin
      mask_a = 4'b1111;
      case (hsize)
         3'b000:  mask_a = 4'b0001 << haddr[1:0];
         3'b001:  mask_a = haddr[1] ? 4'b1100 : 4'b0011;
         default: mask_a = 4'b1111;
      endcase
   end

   always_comb begin
      decode_nx = ST_IDLE;
      if (accept) begin
         if (illegal) begin
`ifdef AHB_SRAM_ERR_RESP_EN
            decode_nx = ST_ERR1;
`else
            decode_nx = ST_ACCESS;
`endif
         end else if (bist_busy) begin
            decode_nx = ST_STALL;
         end else begin
            decode_nx = ST_ACCESS;
         end
      end
   end

   always_comb begin
      state_nx = ST_IDLE;
      case (state)
         ST_IDLE, ST_ACCESS: state_nx = decode_nx;
         ST_STALL:           state_nx = bist_busy ? ST_STALL : ST_ACCESS;
         ST_ERR1:            state_nx = ST_ERR2;
         default:            state_nx = ST_IDLE;
      endcase
   end

   // Address phase -> data phase register
   always_ff @(posedge sram_clk or posedge sram_rst) begin
      if (sram_rst) begin
         state     <= ST_IDLE;
         addr_p0   <= '0;
         write_p0  <= 1'b0;
         ill_p0    <= 1'b0;
         mask_p0   <= '0;
         bist_fail <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            addr_p0  <= haddr[SRAM_AW+1:2];
            write_p0 <= hwrite;
            ill_p0   <= illegal;
            mask_p0  <= mask_a;
         end
         if (|b_fail) bist_fail <= 1'b1;
      end
   end

   // Data phase: bank strobes and read return
   assign in_access  = (state == ST_ACCESS) & ~ill_p0;
   assign sram_addr  = addr_p0;
   assign sram_wdata = hwdata;
   assign sram_csn   = in_access ? (write_p0 ? ~mask_p0 : '0) : '1;
   assign sram_wen   = (in_access & write_p0) ? ~mask_p0 : '1;
   assign hrdata     = (in_access & ~write_p0) ? sram_rdata : '0;
   assign hreadyout  = ~((state == ST_STALL) | (state == ST_ERR1));
   assign hresp      = (state == ST_ERR1) | (state == ST_ERR2);

endmodule
